// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_pkg
// Purpose  : Shared widths and result type for the writeback arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package wb_arbiter_pkg;

  localparam int WAYS  = 4;
  localparam int XLEN  = 32;
  localparam int PRF   = 64;
  localparam int IDX_W = $clog2(PRF);

  typedef logic [IDX_W-1:0] prf_idx_t;

  typedef struct packed {
    prf_idx_t        idx;
    logic [XLEN-1:0] dat;
  } wb_result_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : Small per-FU result FIFO with synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic                       push,
  input  wb_result_t                 push_data,
  input  logic                       pop,
  output wb_result_t                 head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_result_t       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && !full;

  always_ff @(posedge clock) begin
    if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Round-robin writeback arbiter, FU_NUM result FIFOs onto WAYS
//            registered PRF write / CDB lanes. Define WB_BYPASS_EN to let an
//            empty FIFO's incoming result be granted in its arrival cycle.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int FU_NUM    = 6,
  parameter int BUF_DEPTH = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              squash,
  input  logic [FU_NUM-1:0]                 fu_valid,
  input  logic [FU_NUM-1:0][IDX_W-1:0]      fu_prf_idx,
  input  logic [FU_NUM-1:0][XLEN-1:0]       fu_dat,
  output logic [FU_NUM-1:0]                 fu_ready,
  output logic [WAYS-1:0]                   wr_en,
  output logic [WAYS-1:0][IDX_W-1:0]        wr_idx,
  output logic [WAYS-1:0][XLEN-1:0]         wr_dat
);

  localparam int RR_W  = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic             clear;
  logic [FU_NUM-1:0] empty, full, push, pop, keep, cand, grant;
  logic [CNT_W-1:0] count    [FU_NUM];
  wb_result_t       head     [FU_NUM];
  wb_result_t       in_res   [FU_NUM];
  wb_result_t       cand_res [FU_NUM];
  wb_result_t       lane_res [WAYS];
  logic [WAYS-1:0]  lane_en;
  logic [RR_W-1:0]  rr_ptr;
  logic [RR_W-1:0]  rr_next;

  assign clear = reset | squash;

  for (genvar i = 0; i < FU_NUM; i++) begin : g_fu
    assign fu_ready[i] = (count[i] < CNT_W'(BUF_DEPTH)) && !clear;
    // Index 0 completes the handshake but is never buffered or written.
    assign keep[i]     = fu_valid[i] && fu_ready[i] && (fu_prf_idx[i] != '0);
    assign in_res[i]   = '{idx: fu_prf_idx[i], dat: fu_dat[i]};
`ifdef WB_BYPASS_EN
    assign cand[i]     = !empty[i] || keep[i];
    assign cand_res[i] = empty[i] ? in_res[i] : head[i];
    assign push[i]     = keep[i] && !full[i] && !(empty[i] && grant[i]);
`else
    assign cand[i]     = !empty[i];
    assign cand_res[i] = head[i];
    assign push[i]     = keep[i] && !full[i];
`endif
    assign pop[i]      = grant[i] && !empty[i];

    wb_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
      .clock     (clock),
      .clear     (clear),
      .push      (push[i]),
      .push_data (in_res[i]),
      .pop       (pop[i]),
      .head      (head[i]),
      .count     (count[i]),
      .empty     (empty[i]),
      .full      (full[i])
    );
  end

  // Scan from rr_ptr, handing the k-th candidate found to lane k.
  always_comb begin
    int f;
    int n;
    f       = 0;
    n       = 0;
    grant   = '0;
    lane_en = '0;
    rr_next = rr_ptr;
    for (int k = 0; k < WAYS; k++) lane_res[k] = '0;
    for (int s = 0; s < FU_NUM; s++) begin
      f = int'(rr_ptr) + s;
      if (f >= FU_NUM) f = f - FU_NUM;
      if (cand[f] && (n < WAYS)) begin
        grant[f]    = 1'b1;
        lane_en[n]  = 1'b1;
        lane_res[n] = cand_res[f];
        n           = n + 1;
        rr_next     = (f == FU_NUM - 1) ? '0 : RR_W'(f + 1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_en  <= '0;
      wr_idx <= '0;
      wr_dat <= '0;
      rr_ptr <= '0;
    end else if (squash) begin
      wr_en  <= '0;
      rr_ptr <= '0;
    end else begin
      wr_en  <= lane_en;
      rr_ptr <= rr_next;
      for (int k = 0; k < WAYS; k++) begin
        wr_idx[k] <= lane_res[k].idx;
        wr_dat[k] <= lane_res[k].dat;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Self-checking bench for wb_arbiter against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int FU_NUM    = 6;
  localparam int BUF_DEPTH = 2;

  logic                         clock = 1'b0;
  logic                         reset;
  logic                         squash;
  logic [FU_NUM-1:0]            fu_valid;
  logic [FU_NUM-1:0][IDX_W-1:0] fu_prf_idx;
  logic [FU_NUM-1:0][XLEN-1:0]  fu_dat;
  logic [FU_NUM-1:0]            fu_ready;
  logic [WAYS-1:0]              wr_en;
  logic [WAYS-1:0][IDX_W-1:0]   wr_idx;
  logic [WAYS-1:0][XLEN-1:0]    wr_dat;

  int vectors = 0;
  int fails   = 0;

  wb_result_t mq  [FU_NUM][$];   // model: buffered results per FU
  wb_result_t src [FU_NUM][$];   // results each FU still has to offer
  int         m_rr = 0;
  logic [WAYS-1:0] e_en;
  wb_result_t e_lane [WAYS];
  bit         chk_all;

  wb_arbiter #(.FU_NUM(FU_NUM), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .squash     (squash),
    .fu_valid   (fu_valid),
    .fu_prf_idx (fu_prf_idx),
    .fu_dat     (fu_dat),
    .fu_ready   (fu_ready),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_dat     (wr_dat)
  );

  always #5 clock = ~clock;

  function automatic wb_result_t mk(input int idx, input logic [XLEN-1:0] dat);
    wb_result_t r;
    r.idx = prf_idx_t'(idx);
    r.dat = dat;
    return r;
  endfunction

  task automatic drop_sources();
    for (int i = 0; i < FU_NUM; i++) src[i].delete();
  endtask

  // One clock: drive offers, check ready, advance the model, check outputs.
  task automatic cycle(input bit rs, input bit sq);
    logic [FU_NUM-1:0] rdy;
    logic [FU_NUM-1:0] took;
    bit         byp [FU_NUM];
    int         gf[$];
    wb_result_t gr[$];
    int         f;
    reset  = rs;
    squash = sq;
    for (int i = 0; i < FU_NUM; i++) begin
      fu_valid[i] = (src[i].size() > 0);
      if (src[i].size() > 0) begin
        fu_prf_idx[i] = src[i][0].idx;
        fu_dat[i]     = src[i][0].dat;
      end else begin
        fu_prf_idx[i] = '0;
        fu_dat[i]     = '0;
      end
    end
    #1;
    for (int i = 0; i < FU_NUM; i++) begin
      rdy[i] = (mq[i].size() < BUF_DEPTH) && !rs && !sq;
      byp[i] = 1'b0;
    end
    vectors++;
    assert (fu_ready === rdy) else begin
      fails++;
      $error("FAIL fu_ready observed=%b expected=%b", fu_ready, rdy);
    end
    took = rdy & fu_valid;

    for (int s = 0; s < FU_NUM; s++) begin
      f = (m_rr + s) % FU_NUM;
      if (gf.size() < WAYS) begin
        if (mq[f].size() > 0) begin
          gf.push_back(f);
          gr.push_back(mq[f][0]);
        end
`ifdef WB_BYPASS_EN
        else if (took[f] && src[f][0].idx != '0) begin
          gf.push_back(f);
          gr.push_back(src[f][0]);
          byp[f] = 1'b1;
        end
`endif
      end
    end

    e_en = '0;
    if (rs || sq) begin
      for (int i = 0; i < FU_NUM; i++) mq[i].delete();
      m_rr = 0;
      for (int k = 0; k < WAYS; k++) e_lane[k] = '0;
      chk_all = rs;
    end else begin
      chk_all = 1'b0;
      for (int k = 0; k < gf.size(); k++) begin
        e_en[k]   = 1'b1;
        e_lane[k] = gr[k];
        if (!byp[gf[k]]) void'(mq[gf[k]].pop_front());
      end
      for (int i = 0; i < FU_NUM; i++)
        if (took[i] && src[i][0].idx != '0 && !byp[i]) mq[i].push_back(src[i][0]);
      if (gf.size() > 0) m_rr = (gf[gf.size()-1] + 1) % FU_NUM;
    end
    for (int i = 0; i < FU_NUM; i++)
      if (took[i]) void'(src[i].pop_front());

    @(posedge clock);
    #1;
    vectors++;
    assert (wr_en === e_en) else begin
      fails++;
      $error("FAIL wr_en observed=%b expected=%b", wr_en, e_en);
    end
    vectors++;
    assert (dut.rr_ptr === 3'(m_rr)) else begin
      fails++;
      $error("FAIL rr_ptr observed=%0d expected=%0d", dut.rr_ptr, m_rr);
    end
    for (int k = 0; k < WAYS; k++) begin
      if (e_en[k] || chk_all) begin
        vectors++;
        assert (wr_idx[k] === e_lane[k].idx && wr_dat[k] === e_lane[k].dat) else begin
          fails++;
          $error("FAIL lane%0d observed=%0d/%h expected=%0d/%h",
                 k, wr_idx[k], wr_dat[k], e_lane[k].idx, e_lane[k].dat);
        end
      end
    end
  endtask

  initial begin
    bit rs;
    bit sq;
    reset      = 1'b1;
    squash     = 1'b0;
    fu_valid   = '0;
    fu_prf_idx = '0;
    fu_dat     = '0;

    // reset state
    cycle(1, 0);
    cycle(1, 0);

    // light load: single result on FU2
    src[2].push_back(mk(5, 32'hDEADBEEF));
    repeat (4) cycle(0, 0);

    // index 0 is swallowed
    src[0].push_back(mk(0, 32'h0000_1234));
    repeat (3) cycle(0, 0);

    // oversubscription: three results from every FU
    for (int i = 0; i < FU_NUM; i++)
      for (int r = 0; r < 3; r++)
        src[i].push_back(mk(8 + 3 * i + r, {16'hA000 + 16'(i), 16'(r)}));
    repeat (8) cycle(0, 0);

    // squash with a full set buffered and FU1 offering
    for (int i = 0; i < FU_NUM; i++) src[i].push_back(mk(40 + i, 32'h5000_0000 + i));
    cycle(0, 0);
    src[1].push_back(mk(50, 32'h5151_5151));
    cycle(0, 1);
    drop_sources();
    src[3].push_back(mk(33, 32'hCAFE_0033));
    repeat (4) cycle(0, 0);

    // reset in the middle of traffic
    for (int i = 0; i < FU_NUM; i++) begin
      src[i].push_back(mk(20 + i, 32'h7000_0000 + i));
      src[i].push_back(mk(30 + i, 32'h7100_0000 + i));
    end
    repeat (2) cycle(0, 0);
    cycle(1, 0);
    drop_sources();
    repeat (3) cycle(0, 0);

    // randomized traffic with occasional squash/reset
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < FU_NUM; i++)
        if (src[i].size() == 0 && $urandom_range(99) < 65)
          src[i].push_back(mk(($urandom_range(7) == 0) ? 0 : int'($urandom_range(PRF - 1)),
                              $urandom));
      sq = ($urandom_range(99) < 2);
      rs = ($urandom_range(199) == 0);
      cycle(rs, sq);
      if (rs || sq) drop_sources();
    end

    drop_sources();
    repeat (6) cycle(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter: the write side feeding the physical register file's `WAYS` write ports. It collects completed results from `FU_NUM` functional units over valid/ready handshakes and buffers them in small per-unit FIFOs. Each cycle it grants up to `WAYS` buffered results in round-robin order and drives them, registered, onto the PRF write ports, which also serve as the CDB broadcast.

## Interface
- `WAYS`, 4: PRF write ports / CDB lanes.
- `FU_NUM`, 6: functional-unit result sources.
- `XLEN`, 32: data width.
- `PRF`, 64: physical registers; index width `$clog2(PRF)`.
- `BUF_DEPTH`, 2: entries per FU FIFO, power of two, at least 1.
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `squash`  in  1  mispredict flush; synchronous, active-high.
- `fu_valid`  in  `[FU_NUM]`  result offered by the FU.
- `fu_prf_idx`  in  `[FU_NUM][$clog2(PRF)]`  destination physical register.
- `fu_dat`  in  `[FU_NUM][XLEN]`  result data.
- `fu_ready`  out  `[FU_NUM]`  the arbiter can accept the result this cycle.
- `wr_en`  out  `[WAYS]`  PRF write / CDB lane valid.
- `wr_idx`  out  `[WAYS][$clog2(PRF)]`  destination index per lane.
- `wr_dat`  out  `[WAYS][XLEN]`  data per lane.

## Operation
- **Accept:** FU i transfers a result on a rising edge where `fu_valid[i] && fu_ready[i]`.
- **Ready rule:** `fu_ready[i] = (count[i] < BUF_DEPTH) && !squash && !reset`.
  - Ready depends on the count at the start of the cycle.
  - A full FIFO stays not-ready even when it is popped in the same cycle.
- **Index 0:** a result with `fu_prf_idx == 0` is accepted (handshake completes) and discarded. It is never buffered or written.
- **Arbitration:**
  - A FIFO is a candidate when it is non-empty.
  - Scan starts at `rr_ptr` and wraps modulo `FU_NUM`.
  - The first `min(WAYS, candidates)` heads are granted.
  - Lane k gets the k-th grant in scan order; unused lanes have `wr_en = 0`.
  - Granted heads pop at the edge.
- **rr_ptr update:**
  - With at least one grant, it moves to (last granted FU + 1) mod `FU_NUM`.
  - With no grant, it is unchanged.
- **Output register:** `wr_en`, `wr_idx` and `wr_dat` load from the grant result every edge.
- **Ordering:**
  - Results from one FU reach the ports in acceptance order.
  - No ordering is guaranteed across FUs.
- **Duplicate destinations:** not checked. Renaming guarantees unique in-flight destinations.
- **Squash:**
  - On the edge where `squash = 1`, all FIFOs are emptied and all `wr_en` clear.
  - `rr_ptr` resets to 0.
  - Inputs in that cycle are not accepted.
  - The output register still updates, to all-invalid.
- **Reset:**
  - `wr_en = 0`, `wr_idx = 0`, `wr_dat = 0`.
  - `rr_ptr = 0`, all counts 0.
  - `fu_ready = 0` while reset is high.
  - A reset mid-operation discards all buffered results.

## Timing
- **Without bypass:** a result accepted at edge E0 is granted during the following cycle and appears on `wr_*` after edge E1. That is 2 cycles from the `fu_valid` cycle to `wr_en`.
- **Throughput:** at most `WAYS` writes per cycle, and at most one pop per FU per cycle.
- **Stalls:** a persistent oversubscription backs up the FIFOs and deasserts `fu_ready`. There is no data loss.
- **Starvation bound:** a non-empty FIFO is granted within `ceil(FU_NUM/WAYS)` cycles.
- **Simultaneous push and pop:** on a non-full FIFO the count is unchanged, the head advances and the new entry is appended.

## Configuration
- **`WB_BYPASS_EN` defined:**
  - An FU whose FIFO is empty and whose offered result is accepted this cycle (index ≠ 0) is a candidate in the same cycle, and is granted straight from the inputs.
  - A granted bypass result is not written into the FIFO.
  - An arriving result that is not granted is enqueued as usual.
  - Latency is 1 cycle.
- **`WB_BYPASS_EN` undefined:** only FIFO heads are candidates, giving the 2-cycle latency above.

## Structure
- **Shared package:**
  - `prf_idx_t` (`$clog2(PRF)` bits).
  - A struct `wb_result_t` holding `{prf_idx_t idx; logic [XLEN-1:0] dat;}`.
  - The `WAYS`, `XLEN` and `PRF` constants.
- **Sub-module `wb_fifo`:**
  - One instance per FU.
  - Parameterised by `BUF_DEPTH`.
  - Provides push/pop, exposes head, count, empty and full.
  - Has a synchronous clear used by both squash and reset.
- The top level holds the round-robin selector, `rr_ptr` and the output register.

## Test plan
- **Light load:** FU2 offers idx 5 / 0xDEADBEEF after reset; all other FUs idle → `fu_ready[2] = 1`; 2 cycles later lane 0 shows `wr_en = 1`, idx 5, 0xDEADBEEF. With `WB_BYPASS_EN` this appears after 1 cycle.
- **Oversubscription:** all 6 FUs offer for 3 consecutive cycles (18 results) → 4 writes per cycle, all 18 retire in 5 cycles. Per-FU order is preserved, and `fu_ready` drops on full FIFOs. `rr_ptr` goes 0→4→2→0→4.
- **Index 0:** FU0 offers idx 0 → handshake completes, no `wr_en` ever asserts, and FU0's FIFO count stays 0.
- **Squash:** squash with 6 results buffered and FU1 offering → no further `wr_en`, the FU1 result is dropped, `fu_ready` is low during the squash cycle, and fresh traffic flows 2 cycles after.
- **Reset mid-traffic:** outputs are 0 on the next cycle and `fu_ready` stays low until reset deasserts; no buffered data appears afterwards.
- **Full FIFO:** full FIFO, simultaneous pop, FU still valid → not accepted that cycle, accepted next cycle; the result order out of the FIFO is intact.
